// File: rtl/axi_fifo_rr_scheduler_if.sv
// Handshake/bus bundle between four show-ahead request FIFOs, the scheduler
// and the downstream channel.
interface axi_fifo_rr_scheduler_if #(
  parameter int D_WIDTH = 101
);
  logic [3:0]           i_empty;
  logic [4*D_WIDTH-1:0] i_data;
  logic [3:0]           o_pop;
  logic                 o_valid;
  logic [D_WIDTH-1:0]   o_data;
  logic [1:0]           o_src;
  logic                 i_ready;
  logic                 o_locked;

  modport master (
    input  i_empty, i_data, i_ready,
    output o_pop, o_valid, o_data, o_src, o_locked
  );

  modport slave (
    output i_empty, i_data, i_ready,
    input  o_pop, o_valid, o_data, o_src, o_locked
  );
endinterface

// File: rtl/axi_fifo_rr_scheduler.sv
// Round-robin scheduler sharing one output channel between four FIFOs,
// with atomic bursts and a one-entry registered output stage.
module axi_fifo_rr_scheduler #(
  parameter int D_WIDTH  = 101,
  parameter int LAST_BIT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axi_fifo_rr_scheduler_if.master bus
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         last_grant_q;
  logic               valid_q;
  logic [D_WIDTH-1:0] data_q;
  logic [1:0]         src_q;

  logic [D_WIDTH-1:0] heads [4];
  logic [D_WIDTH-1:0] head;
  logic [1:0]         cand;
  logic [1:0]         scan_idx;
  logic               cand_ok;
  logic               load_en;
  logic [3:0]         pop;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      heads[i] = bus.i_data[i*D_WIDTH +: D_WIDTH];
    end
  end

  // While locked only the burst owner may load; an empty owner yields a bubble.
  always_comb begin
    cand_ok  = 1'b0;
    cand     = src_q;
    scan_idx = '0;
    if (state_q == LOCKED) begin
      cand_ok = !bus.i_empty[src_q];
    end else begin
      for (int unsigned i = 1; i <= 4; i++) begin
        scan_idx = last_grant_q + 2'(i);
        if (!cand_ok && !bus.i_empty[scan_idx]) begin
          cand_ok = 1'b1;
          cand    = scan_idx;
        end
      end
    end
  end

  always_comb begin
    head    = heads[cand];
    load_en = (!valid_q || bus.i_ready) && cand_ok;
    pop     = '0;
    if (load_en && rst_n) begin
      pop[cand] = 1'b1;
    end
    state_d = state_q;
    if (load_en) begin
      state_d = head[LAST_BIT] ? IDLE : LOCKED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 2'd3;
      valid_q      <= 1'b0;
      data_q       <= '0;
      src_q        <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        data_q       <= head;
        src_q        <= cand;
        valid_q      <= 1'b1;
        last_grant_q <= cand;
      end else if (bus.i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_pop    = pop;
  assign bus.o_valid  = valid_q;
  assign bus.o_data   = data_q;
  assign bus.o_src    = src_q;
  assign bus.o_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_axi_fifo_rr_scheduler.sv
// Directed bench for axi_fifo_rr_scheduler with behavioural show-ahead FIFOs.
module tb_axi_fifo_rr_scheduler;
  localparam int D = 101;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  axi_fifo_rr_scheduler_if #(.D_WIDTH(D)) bus ();

  axi_fifo_rr_scheduler #(.D_WIDTH(D), .LAST_BIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO models: written by the stimulus, popped by the DUT, flushed by reset.
  logic [D-1:0] mem [4][256];
  int           wr_ptr [4];
  int           rd_ptr [4];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n)               rd_ptr[k] <= wr_ptr[k];
      else if (bus.o_pop[k])    rd_ptr[k] <= rd_ptr[k] + 1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.i_empty[k]          = (rd_ptr[k] == wr_ptr[k]);
      bus.i_data[k*D +: D]    = mem[k][rd_ptr[k] % 256];
    end
  end

  function automatic logic [D-1:0] mk(int s, int n, bit l);
    logic [D-1:0] b;
    b       = '0;
    b[16:9] = 8'(s);
    b[8:1]  = 8'(n);
    b[0]    = l;
    return b;
  endfunction

  task automatic push(int k, logic [D-1:0] v);
    mem[k][wr_ptr[k] % 256] = v;
    wr_ptr[k] = wr_ptr[k] + 1;
  endtask

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int k = 0; k < 4; k++) begin
      wr_ptr[k] = 0;
      rd_ptr[k] = 0;
    end
    rst_n       = 1'b0;
    bus.i_ready = 1'b1;

    // Reset state and reset priority
    cyc();
    cyc();
    check("rst_valid", 128'(bus.o_valid), 128'(0));
    check("rst_data", 128'(bus.o_data), 128'(0));
    check("rst_src", 128'(bus.o_src), 128'(0));
    check("rst_locked", 128'(bus.o_locked), 128'(0));
    @(negedge clk);
    for (int k = 0; k < 4; k++) push(k, mk(k, 0, 1'b1));
    #1;
    check("rst_pop_forced", 128'(bus.o_pop), 128'(0));
    rst_n = 1'b1;
    #1;
    check("prio_pop0", 128'(bus.o_pop), 128'(4'b0001));
    cyc();
    check("prio_src0", 128'(bus.o_src), 128'(0));
    check("prio_data0", 128'(bus.o_data), 128'(mk(0, 0, 1'b1)));
    check("prio_valid0", 128'(bus.o_valid), 128'(1));
    check("prio_pop1", 128'(bus.o_pop), 128'(4'b0010));
    cyc();
    check("prio_src1", 128'(bus.o_src), 128'(1));
    check("prio_pop2", 128'(bus.o_pop), 128'(4'b0100));
    cyc();
    check("prio_src2", 128'(bus.o_src), 128'(2));
    check("prio_pop3", 128'(bus.o_pop), 128'(4'b1000));
    cyc();
    check("prio_src3", 128'(bus.o_src), 128'(3));
    check("prio_valid3", 128'(bus.o_valid), 128'(1));
    check("prio_pop_none", 128'(bus.o_pop), 128'(0));
    cyc();
    check("prio_valid_drop", 128'(bus.o_valid), 128'(0));

    // Burst lock: src1 three beats, src2 one beat
    @(negedge clk);
    push(1, mk(1, 0, 1'b0));
    push(1, mk(1, 1, 1'b0));
    push(1, mk(1, 2, 1'b1));
    push(2, mk(2, 0, 1'b1));
    #1;
    check("lock_pop_a", 128'(bus.o_pop), 128'(4'b0010));
    cyc();
    check("lock_src_b0", 128'(bus.o_src), 128'(1));
    check("lock_locked_b0", 128'(bus.o_locked), 128'(1));
    check("lock_pop_b", 128'(bus.o_pop), 128'(4'b0010));
    cyc();
    check("lock_src_b1", 128'(bus.o_src), 128'(1));
    check("lock_locked_b1", 128'(bus.o_locked), 128'(1));
    check("lock_pop_c", 128'(bus.o_pop), 128'(4'b0010));
    cyc();
    check("lock_src_b2", 128'(bus.o_src), 128'(1));
    check("lock_data_b2", 128'(bus.o_data), 128'(mk(1, 2, 1'b1)));
    check("lock_locked_b2", 128'(bus.o_locked), 128'(0));
    check("lock_pop_src2", 128'(bus.o_pop), 128'(4'b0100));
    cyc();
    check("lock_src_s2", 128'(bus.o_src), 128'(2));
    check("lock_pop_none", 128'(bus.o_pop), 128'(0));
    cyc();
    check("lock_valid_drop", 128'(bus.o_valid), 128'(0));

    // Backpressure
    @(negedge clk);
    bus.i_ready = 1'b0;
    push(0, mk(0, 1, 1'b1));
    push(0, mk(0, 2, 1'b1));
    #1;
    check("bp_pop_empty_stage", 128'(bus.o_pop), 128'(4'b0001));
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("bp_hold_data", 128'(bus.o_data), 128'(mk(0, 1, 1'b1)));
      check("bp_hold_valid", 128'(bus.o_valid), 128'(1));
      check("bp_no_pop", 128'(bus.o_pop), 128'(0));
    end
    @(negedge clk);
    bus.i_ready = 1'b1;
    #1;
    check("bp_release_pop", 128'(bus.o_pop), 128'(4'b0001));
    cyc();
    check("bp_next_data", 128'(bus.o_data), 128'(mk(0, 2, 1'b1)));
    check("bp_next_valid", 128'(bus.o_valid), 128'(1));
    cyc();
    check("bp_valid_drop", 128'(bus.o_valid), 128'(0));

    // Locked-source underflow
    @(negedge clk);
    push(0, mk(0, 3, 1'b0));
    #1;
    check("uf_pop0", 128'(bus.o_pop), 128'(4'b0001));
    @(negedge clk);
    push(3, mk(3, 0, 1'b1));
    #1;
    check("uf_locked", 128'(bus.o_locked), 128'(1));
    check("uf_no_pop3", 128'(bus.o_pop), 128'(0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("uf_bubble_valid", 128'(bus.o_valid), 128'(0));
      check("uf_bubble_locked", 128'(bus.o_locked), 128'(1));
      check("uf_bubble_pop", 128'(bus.o_pop), 128'(0));
    end
    @(negedge clk);
    push(0, mk(0, 4, 1'b1));
    #1;
    check("uf_resume_pop", 128'(bus.o_pop), 128'(4'b0001));
    cyc();
    check("uf_last_data", 128'(bus.o_data), 128'(mk(0, 4, 1'b1)));
    check("uf_unlocked", 128'(bus.o_locked), 128'(0));
    check("uf_pop3", 128'(bus.o_pop), 128'(4'b1000));
    cyc();
    check("uf_src3", 128'(bus.o_src), 128'(3));
    cyc();
    check("uf_valid_drop", 128'(bus.o_valid), 128'(0));

    // Round-robin fairness with 2-beat bursts
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 5; n++) begin
        push(k, mk(k, 2*n, 1'b0));
        push(k, mk(k, 2*n + 1, 1'b1));
      end
    end
    #1;
    check("rr_pop_first", 128'(bus.o_pop), 128'(4'b0001));
    for (int c = 0; c < 40; c++) begin
      logic [3:0] exp_pop;
      exp_pop = '0;
      if (c + 1 < 40) exp_pop[((c + 1) / 2) % 4] = 1'b1;
      cyc();
      check("rr_src", 128'(bus.o_src), 128'((c / 2) % 4));
      check("rr_locked", 128'(bus.o_locked), 128'((c % 2) == 0));
      check("rr_pop", 128'(bus.o_pop), 128'(exp_pop));
    end
    cyc();
    check("rr_valid_drop", 128'(bus.o_valid), 128'(0));

    // Reset mid-burst
    @(negedge clk);
    for (int n = 0; n < 4; n++) push(1, mk(1, n, n == 3));
    #1;
    check("mr_pop_a", 128'(bus.o_pop), 128'(4'b0010));
    cyc();
    check("mr_pop_b", 128'(bus.o_pop), 128'(4'b0010));
    cyc();
    check("mr_beat2", 128'(bus.o_data), 128'(mk(1, 1, 1'b0)));
    check("mr_locked_pre", 128'(bus.o_locked), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_valid_async", 128'(bus.o_valid), 128'(0));
    check("mr_locked_async", 128'(bus.o_locked), 128'(0));
    check("mr_pop_async", 128'(bus.o_pop), 128'(0));
    check("mr_data_async", 128'(bus.o_data), 128'(0));
    cyc();
    @(negedge clk);
    push(2, mk(2, 0, 1'b1));
    push(3, mk(3, 0, 1'b1));
    rst_n = 1'b1;
    #1;
    check("mr_first_pop", 128'(bus.o_pop), 128'(4'b0100));
    cyc();
    check("mr_first_src", 128'(bus.o_src), 128'(2));
    check("mr_second_pop", 128'(bus.o_pop), 128'(4'b1000));
    cyc();
    check("mr_second_src", 128'(bus.o_src), 128'(3));
    check("mr_pop_none", 128'(bus.o_pop), 128'(0));
    cyc();
    check("mr_valid_drop", 128'(bus.o_valid), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
